// File: rtl/ram_dump_module.sv
// 16x8 register-file RAM filled from the copy stage, dumped in address order
// over a valid/ready handshake while accumulating an 8-bit checksum.
module ram_dump_module (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start_sig,
  input  logic       dump_ready,
  output logic       dump_valid,
  output logic [3:0] dump_addr,
  output logic [7:0] dump_data,
  output logic       dump_done,
  output logic [7:0] checksum,
  output logic       busy,
  output logic       wr_err
);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] mem_q [16];
  logic [3:0] addr_q, addr_d, addr_nxt;
  logic [7:0] data_q, data_d;
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
  logic       start_ok, accept, wr_ok;

  assign start_ok = (state_q == IDLE) && start_sig;
  assign accept   = (state_q == DUMP) && dump_ready;
  assign wr_ok    = (state_q == IDLE) && write_en;
  assign addr_nxt = addr_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_sig) state_d = DUMP;
      DUMP:    if (dump_ready && (addr_q == 4'hF)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dump_valid = (state_q == DUMP);
    dump_done  = (state_q == DONE);
    busy       = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Beat 0 forwards a same-cycle write to address 0 so the start edge sees new data.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    sum_d  = sum_q;
    err_d  = err_q;
    if (write_en && (state_q != IDLE)) err_d = 1'b1;
    if (start_ok) begin
      addr_d = '0;
      data_d = (write_en && (wr_addr == 4'd0)) ? wr_data : mem_q[0];
      sum_d  = '0;
      err_d  = 1'b0;
    end else if (accept) begin
      sum_d  = sum_q + data_q;
      addr_d = addr_nxt;
      data_d = mem_q[addr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      sum_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      sum_q  <= sum_d;
      err_q  <= err_d;
    end
  end

  assign dump_addr = addr_q;
  assign dump_data = data_q;
  assign checksum  = sum_q;
  assign wr_err    = err_q;

endmodule

// File: tb/tb_ram_dump_module.sv
// Scoreboard bench for ram_dump_module: expected beats are queued at start and
// popped as the DUT presents accepted beats.
module tb_ram_dump_module;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start_sig = 1'b0;
  logic       dump_ready = 1'b0;
  logic       dump_valid, dump_done, busy, wr_err;
  logic [3:0] dump_addr;
  logic [7:0] dump_data, checksum;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_mem [16];
  logic [11:0] sb_q [$];

  always #5 clk = ~clk;

  ram_dump_module dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start_sig(start_sig), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done), .checksum(checksum), .busy(busy), .wr_err(wr_err)
  );

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    write_en = 1'b1; wr_addr = a; wr_data = d;
    exp_mem[a] = d;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic issue_start(input bit with_wr, input logic [3:0] a, input logic [7:0] d);
    start_sig = 1'b1;
    if (with_wr) begin
      write_en = 1'b1; wr_addr = a; wr_data = d; exp_mem[a] = d;
    end
    for (int k = 0; k < 16; k++) sb_q.push_back({4'(k), exp_mem[k]});
    @(posedge clk); #1;
    start_sig = 1'b0; write_en = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high every third cycle.
  task automatic run_dump(input int mode, input int inject_at, input bit abort7,
                          input logic [7:0] exp_sum);
    logic [11:0] e;
    logic [3:0]  pa;
    logic [7:0]  pd;
    bit          prev_hold, done_seen;
    prev_hold = 1'b0; done_seen = 1'b0; pa = '0; pd = '0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      dump_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (c == inject_at) begin
        write_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hFF; start_sig = 1'b1;
      end
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== pa || dump_data !== pd) begin
          errors++;
          $display("FAIL hold c=%0d: valid=%b addr=%h data=%h, want valid=1 addr=%h data=%h",
                   c, dump_valid, dump_addr, dump_data, pa, pd);
        end
      end
      prev_hold = dump_valid && !dump_ready;
      pa = dump_addr; pd = dump_data;
      if (abort7 && dump_valid && dump_addr == 4'd7) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dump_valid, dump_addr, dump_data, dump_done, checksum, busy, wr_err} !== '0) begin
          errors++;
          $display("FAIL reset_mid: valid=%b addr=%h data=%h done=%b sum=%h busy=%b err=%b, want all 0",
                   dump_valid, dump_addr, dump_data, dump_done, checksum, busy, wr_err);
        end
        sb_q.delete();
        for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;
        dump_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (dump_valid && dump_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: addr=%h data=%h, want no beat", dump_addr, dump_data);
        end else begin
          e = sb_q.pop_front();
          if ({dump_addr, dump_data} !== e) begin
            errors++;
            $display("FAIL beat: addr=%h data=%h, want addr=%h data=%h",
                     dump_addr, dump_data, e[11:8], e[7:0]);
          end
        end
      end
      if (dump_done) begin
        done_seen = 1'b1;
        checks++;
        if (checksum !== exp_sum || busy !== 1'b1 || dump_valid !== 1'b0) begin
          errors++;
          $display("FAIL done: sum=%h busy=%b valid=%b, want sum=%h busy=1 valid=0",
                   checksum, busy, dump_valid, exp_sum);
        end
        checks++;
        if (sb_q.size() != 0) begin
          errors++;
          $display("FAIL missing_beats: left=%0d, want 0", sb_q.size());
        end
        if (mode == 0) begin
          checks++;
          if (c != 16) begin
            errors++;
            $display("FAIL done_cycle: got %0d, want 16", c);
          end
        end
      end
      @(posedge clk); #1;
      if (c == inject_at) begin
        write_en = 1'b0; start_sig = 1'b0;
      end
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL timeout: dump_done not seen, want done within 100 cycles");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dump_done !== 1'b0 || checksum !== exp_sum) begin
      errors++;
      $display("FAIL idle: busy=%b done=%b sum=%h, want busy=0 done=0 sum=%h",
               busy, dump_done, checksum, exp_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dump_valid, dump_addr, dump_data, dump_done, checksum, busy, wr_err} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b addr=%h data=%h done=%b sum=%h busy=%b err=%b, want all 0",
               dump_valid, dump_addr, dump_data, dump_done, checksum, busy, wr_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_dump();
    issue_start(1'b0, 4'd0, 8'h00);
    run_dump(0, -1, 1'b0, 8'h00);
  endtask

  task automatic test_pattern();
    for (int k = 0; k < 16; k++) do_write(4'(k), 8'hA0 + 8'(k));
    issue_start(1'b0, 4'd0, 8'h00);
    run_dump(0, -1, 1'b0, 8'h78);
  endtask

  task automatic test_back_to_back();
    issue_start(1'b0, 4'd0, 8'h00);
    run_dump(1, -1, 1'b0, 8'h78);
  endtask

  task automatic test_start_forward();
    issue_start(1'b1, 4'd0, 8'h5A);
    run_dump(0, -1, 1'b0, 8'h32);
    do_write(4'd0, 8'hA0);
  endtask

  task automatic test_write_while_busy();
    issue_start(1'b0, 4'd0, 8'h00);
    run_dump(0, 1, 1'b0, 8'h78);
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_err_set: got %b, want 1", wr_err);
    end
    issue_start(1'b0, 4'd0, 8'h00);
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_clear: got %b, want 0", wr_err);
    end
    run_dump(0, -1, 1'b0, 8'h78);
  endtask

  task automatic test_reset_mid_dump();
    issue_start(1'b0, 4'd0, 8'h00);
    run_dump(0, -1, 1'b1, 8'h00);
    issue_start(1'b0, 4'd0, 8'h00);
    run_dump(0, -1, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_zero_dump();
    test_pattern();
    test_back_to_back();
    test_start_forward();
    test_write_while_busy();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
